// File: rtl/bram_pkg.sv
// Shared types and helpers for the BRAM row packer: lane geometry, packer FSM states,
// write payload and the per-lane byte-enable helper.
package bram_pkg;

  localparam int unsigned WORD_BITS      = 128;
  localparam int unsigned LANE_BITS      = 16;
  localparam int unsigned LANES          = WORD_BITS / LANE_BITS;
  localparam int unsigned BYTES_PER_LANE = LANE_BITS / 8;
  localparam int unsigned WE_BITS        = WORD_BITS / 8;
  localparam int unsigned LANE_IDX_BITS  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    SATURATED
  } packer_state_t;

  typedef logic [WE_BITS-1:0]       we_mask_t;
  typedef logic [LANE_IDX_BITS-1:0] lane_idx_t;

  // One registered BRAM port-A write.
  typedef struct packed {
    logic                 en;
    we_mask_t             we;
    logic [WORD_BITS-1:0] din;
    logic                 done;
  } bram_wr_t;

  // Byte enables covering the bank behind one lane.
  function automatic we_mask_t lane_mask(input lane_idx_t lane);
    return WE_BITS'({BYTES_PER_LANE{1'b1}}) << (32'(lane) * BYTES_PER_LANE);
  endfunction

endpackage

// File: rtl/bram_row_packer_if.sv
// Valid/ready column stream feeding the row packer.
interface bram_row_packer_if
  import bram_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = LANE_BITS
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [LANE_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/bram_word_addr_gen.sv
// Word index for the packed-write stream: base offset, wrap or saturate at DEPTH,
// and the sticky overflow flag.
module bram_word_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [63:0] BASE_ADDR  = '0,
  parameter int unsigned WRAP       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] word_addr_c,
  output logic                  at_last_c,
  output logic                  overflow
);

  localparam int unsigned          IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(DEPTH - 1);

  logic [IDX_WIDTH-1:0] word_idx;

  assign at_last_c   = (word_idx == LAST_IDX);
  assign word_addr_c = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);

  // Past the last word either wrap to 0 or hold the index and flag overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_idx <= '0;
      overflow <= 1'b0;
    end else if (advance) begin
      if (!at_last_c) begin
        word_idx <= word_idx + 1'b1;
      end else if (WRAP != 0) begin
        word_idx <= '0;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_row_packer.sv
// Packs a stream of 16-bit column values into 128-bit BRAM words, one value per
// lane, and issues one port-A write per word with per-lane byte enables.
module bram_row_packer
  import bram_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 40,
  parameter int unsigned BRAM_DATA_WIDTH = WORD_BITS,
  parameter int unsigned LANE_WIDTH      = LANE_BITS,
  parameter int unsigned DEPTH           = 1024,
  parameter logic [63:0] BASE_ADDR       = '0,
  parameter int unsigned WRAP            = 0
) (
  input  logic                         bram_clk_in,
  input  logic                         bram_rst_in,
  input  logic                         clear,
  bram_row_packer_if.slave             s,
  output logic                         bram_clk_a_out,
  output logic                         bram_rst_a_out,
  output logic                         bram_en_a_out,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_we_a_out,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_a_out,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_din_a_out,
  output logic [31:0]                  words_written,
  output logic                         done,
  output logic                         overflow
);

  localparam lane_idx_t LAST_LANE = LANE_IDX_BITS'(LANES - 1);
  localparam bit        SATURATE  = (WRAP == 0);

  packer_state_t              state;
  packer_state_t              state_next;
  logic                       sat_c;
  lane_idx_t                  lane;
  logic [BRAM_DATA_WIDTH-1:0] acc;
  logic [BRAM_DATA_WIDTH-1:0] acc_merged_c;
  we_mask_t                   mask;
  we_mask_t                   mask_merged_c;
  logic                       accept_c;
  logic                       flush_c;
  logic [BRAM_ADDR_WIDTH-1:0] word_addr_c;
  logic                       at_last_c;
  bram_wr_t                   wr_q;

  assign bram_clk_a_out = bram_clk_in;
  assign bram_rst_a_out = bram_rst_in;

  assign s.s_ready = !bram_rst_in && !clear && !sat_c;
  assign accept_c  = s.s_valid && s.s_ready;
  assign flush_c   = accept_c && ((lane == LAST_LANE) || s.s_last);

  // Accumulator and mask as they would look with the current beat merged in.
  always_comb begin
    acc_merged_c = acc;
    acc_merged_c[32'(lane)*LANE_WIDTH +: LANE_WIDTH] = s.s_data;
    mask_merged_c = mask | lane_mask(lane);
  end

  bram_word_addr_gen #(
    .ADDR_WIDTH (BRAM_ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .WRAP       (WRAP)
  ) u_addr_gen (
    .clk         (bram_clk_in),
    .rst         (bram_rst_in),
    .clear       (clear),
    .advance     (flush_c),
    .word_addr_c (word_addr_c),
    .at_last_c   (at_last_c),
    .overflow    (overflow)
  );

  always_ff @(posedge bram_clk_in) begin
    if (bram_rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (flush_c && at_last_c && SATURATE) begin
      state_next = SATURATED;
    end else if (flush_c) begin
      state_next = FLUSH;
    end else if (accept_c) begin
      state_next = FILL;
    end else if (state == FLUSH) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    sat_c = 1'b0;
    if (state == SATURATED) begin
      sat_c = 1'b1;
    end
  end

  // Lane accumulation; a flush hands the merged word to the write register and
  // restarts the row in the same cycle so full-rate rows need no bubble.
  always_ff @(posedge bram_clk_in) begin
    if (bram_rst_in) begin
      lane            <= '0;
      mask            <= '0;
      acc             <= '0;
      wr_q            <= '0;
      bram_addr_a_out <= '0;
      words_written   <= '0;
    end else begin
      wr_q.en   <= flush_c;
      wr_q.we   <= flush_c ? mask_merged_c : '0;
      wr_q.done <= flush_c && s.s_last;
      if (flush_c) begin
        wr_q.din        <= acc_merged_c;
        bram_addr_a_out <= word_addr_c;
        words_written   <= words_written + 32'd1;
      end
      if (clear || flush_c) begin
        lane <= '0;
        mask <= '0;
        acc  <= '0;
      end else if (accept_c) begin
        lane <= lane + 1'b1;
        mask <= mask_merged_c;
        acc  <= acc_merged_c;
      end
      if (clear) begin
        words_written <= '0;
      end
    end
  end

  assign bram_en_a_out  = wr_q.en;
  assign bram_we_a_out  = wr_q.we;
  assign bram_din_a_out = wr_q.din;
  assign done           = wr_q.done;

endmodule

// File: tb/tb_bram_row_packer.sv
// Scoreboard bench: three packers (large region, DEPTH=2 saturating, DEPTH=2 wrapping)
// share one stimulus stream; a behavioural model predicts every write and flag.
module tb_bram_row_packer;

  localparam int unsigned NDUT = 3;
  localparam int unsigned P_DEPTH [NDUT] = '{1024, 2, 2};
  localparam int unsigned P_WRAP  [NDUT] = '{0, 0, 1};
  localparam logic [39:0] P_BASE  [NDUT] = '{40'h100, 40'h0, 40'h10};

  typedef struct {
    logic [39:0]  addr;
    logic [15:0]  we;
    logic [127:0] din;
    logic         done;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, clr, vld, lst;
  logic [15:0] dat;

  logic         rdy     [NDUT];
  logic         clk_a   [NDUT];
  logic         rst_a   [NDUT];
  logic         en      [NDUT];
  logic [15:0]  we      [NDUT];
  logic [39:0]  addr    [NDUT];
  logic [127:0] din     [NDUT];
  logic [31:0]  ww      [NDUT];
  logic         done_o  [NDUT];
  logic         ovf     [NDUT];

  wr_t          exp_q     [NDUT][$];
  int unsigned  m_lane    [NDUT];
  logic [127:0] m_acc     [NDUT];
  logic [15:0]  m_mask    [NDUT];
  int unsigned  m_idx     [NDUT];
  logic [31:0]  m_ww      [NDUT];
  bit           m_ovf     [NDUT];
  logic [39:0]  hold_addr [NDUT];
  logic [127:0] hold_din  [NDUT];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  bram_row_packer_if #(.LANE_WIDTH(16)) sif0 ();
  bram_row_packer_if #(.LANE_WIDTH(16)) sif1 ();
  bram_row_packer_if #(.LANE_WIDTH(16)) sif2 ();

  assign sif0.s_valid = vld; assign sif0.s_data = dat; assign sif0.s_last = lst;
  assign sif1.s_valid = vld; assign sif1.s_data = dat; assign sif1.s_last = lst;
  assign sif2.s_valid = vld; assign sif2.s_data = dat; assign sif2.s_last = lst;
  assign rdy[0] = sif0.s_ready;
  assign rdy[1] = sif1.s_ready;
  assign rdy[2] = sif2.s_ready;

  bram_row_packer #(
    .DEPTH(P_DEPTH[0]), .WRAP(P_WRAP[0]), .BASE_ADDR(64'(P_BASE[0]))
  ) dut0 (
    .bram_clk_in(clk), .bram_rst_in(rst), .clear(clr), .s(sif0.slave),
    .bram_clk_a_out(clk_a[0]), .bram_rst_a_out(rst_a[0]), .bram_en_a_out(en[0]),
    .bram_we_a_out(we[0]), .bram_addr_a_out(addr[0]), .bram_din_a_out(din[0]),
    .words_written(ww[0]), .done(done_o[0]), .overflow(ovf[0])
  );

  bram_row_packer #(
    .DEPTH(P_DEPTH[1]), .WRAP(P_WRAP[1]), .BASE_ADDR(64'(P_BASE[1]))
  ) dut1 (
    .bram_clk_in(clk), .bram_rst_in(rst), .clear(clr), .s(sif1.slave),
    .bram_clk_a_out(clk_a[1]), .bram_rst_a_out(rst_a[1]), .bram_en_a_out(en[1]),
    .bram_we_a_out(we[1]), .bram_addr_a_out(addr[1]), .bram_din_a_out(din[1]),
    .words_written(ww[1]), .done(done_o[1]), .overflow(ovf[1])
  );

  bram_row_packer #(
    .DEPTH(P_DEPTH[2]), .WRAP(P_WRAP[2]), .BASE_ADDR(64'(P_BASE[2]))
  ) dut2 (
    .bram_clk_in(clk), .bram_rst_in(rst), .clear(clr), .s(sif2.slave),
    .bram_clk_a_out(clk_a[2]), .bram_rst_a_out(rst_a[2]), .bram_en_a_out(en[2]),
    .bram_we_a_out(we[2]), .bram_addr_a_out(addr[2]), .bram_din_a_out(din[2]),
    .words_written(ww[2]), .done(done_o[2]), .overflow(ovf[2])
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare the outputs produced by the posedge that just passed.
  task automatic monitor();
    wr_t e;
    for (int k = 0; k < NDUT; k++) begin
      check_val($sformatf("dut%0d_en", k), 128'(en[k]), 128'(exp_q[k].size() != 0));
      if (exp_q[k].size() != 0) begin
        e = exp_q[k].pop_front();
        check_val($sformatf("dut%0d_addr", k), 128'(addr[k]), 128'(e.addr));
        check_val($sformatf("dut%0d_we", k), 128'(we[k]), 128'(e.we));
        check_val($sformatf("dut%0d_din", k), din[k], e.din);
        check_val($sformatf("dut%0d_done", k), 128'(done_o[k]), 128'(e.done));
        hold_addr[k] = e.addr;
        hold_din[k]  = e.din;
      end else begin
        check_val($sformatf("dut%0d_we_idle", k), 128'(we[k]), 128'(0));
        check_val($sformatf("dut%0d_done_idle", k), 128'(done_o[k]), 128'(0));
        check_val($sformatf("dut%0d_addr_hold", k), 128'(addr[k]), 128'(hold_addr[k]));
        check_val($sformatf("dut%0d_din_hold", k), din[k], hold_din[k]);
      end
      check_val($sformatf("dut%0d_words_written", k), 128'(ww[k]), 128'(m_ww[k]));
      check_val($sformatf("dut%0d_overflow", k), 128'(ovf[k]), 128'(m_ovf[k]));
    end
  endtask

  task automatic model_reset(input int k);
    m_lane[k]    = 0;
    m_acc[k]     = '0;
    m_mask[k]    = '0;
    m_idx[k]     = 0;
    m_ww[k]      = '0;
    m_ovf[k]     = 1'b0;
    hold_addr[k] = '0;
    hold_din[k]  = '0;
  endtask

  // Predict the effect of the currently driven inputs at the next posedge.
  task automatic model(input int k);
    bit  rdy_e;
    wr_t e;
    check_val($sformatf("dut%0d_rst_fwd", k), 128'(rst_a[k]), 128'(rst));
    if (rst) begin
      check_val($sformatf("dut%0d_ready_rst", k), 128'(rdy[k]), 128'(0));
      model_reset(k);
      exp_q[k].delete();
      return;
    end
    rdy_e = !clr && !(m_ovf[k] && P_WRAP[k] == 0);
    check_val($sformatf("dut%0d_ready", k), 128'(rdy[k]), 128'(rdy_e));
    if (clr) begin
      m_lane[k] = 0;
      m_acc[k]  = '0;
      m_mask[k] = '0;
      m_idx[k]  = 0;
      m_ww[k]   = '0;
      m_ovf[k]  = 1'b0;
    end else if (vld && rdy_e) begin
      m_acc[k][m_lane[k]*16 +: 16] = dat;
      m_mask[k][m_lane[k]*2 +: 2]  = 2'b11;
      if (m_lane[k] == 7 || lst) begin
        e.addr = P_BASE[k] + 40'(m_idx[k]);
        e.we   = m_mask[k];
        e.din  = m_acc[k];
        e.done = lst;
        exp_q[k].push_back(e);
        m_ww[k] = m_ww[k] + 32'd1;
        if (m_idx[k] == P_DEPTH[k] - 1) begin
          if (P_WRAP[k] != 0) m_idx[k] = 0;
          else m_ovf[k] = 1'b1;
        end else begin
          m_idx[k] = m_idx[k] + 1;
        end
        m_lane[k] = 0;
        m_acc[k]  = '0;
        m_mask[k] = '0;
      end else begin
        m_lane[k] = m_lane[k] + 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [15:0] d, input bit l);
    @(negedge clk);
    monitor();
    rst = r; clr = c; vld = v; dat = d; lst = l;
    #1;
    for (int k = 0; k < NDUT; k++) model(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic beats(input int n, input logic [15:0] first, input bit last_on_final);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b1, first + 16'(i), last_on_final && (i == n - 1));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; dat = '0; lst = 1'b0;
    for (int k = 0; k < NDUT; k++) model_reset(k);
    repeat (2) @(posedge clk);

    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(1);

    // Full row with s_last on the 8th beat.
    beats(8, 16'h0001, 1'b1);
    idle(2);

    // Short row of three.
    step(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hBBBB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b1);
    idle(2);

    // Recover the saturated DEPTH=2 packer, then stream 24 beats back to back.
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1);
    beats(24, 16'h1000, 1'b0);
    idle(2);

    // clear arrives with a sixth valid beat.
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    beats(5, 16'h2000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h6666, 1'b0);
    beats(8, 16'h3000, 1'b0);
    idle(2);

    // Reset mid-row.
    beats(4, 16'h4000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h4444, 1'b0);
    idle(1);
    beats(8, 16'h5000, 1'b0);
    idle(2);

    // s_last on lane 0.
    beats(1, 16'hBEEF, 1'b1);
    idle(2);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++)
      step(1'b0 || ($urandom_range(0, 149) == 0), $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) == 0);
    idle(3);

    for (int k = 0; k < NDUT; k++)
      check_val($sformatf("dut%0d_queue_drained", k), 128'(exp_q[k].size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
